// File: rtl/serial_parity_receiver.sv
// Serial receiver: DATA_W data bits (LSB first) plus one parity bit per frame.
// Ports: clk, rst_n (async low), abort (drop partial frame),
//   in_valid/in_bit/in_ready (serial input handshake),
//   out_valid/out_data/out_perr/out_ready (word output handshake).
module serial_parity_receiver #(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              abort,
   input  logic              in_valid,
   input  logic              in_bit,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_perr,
   input  logic              out_ready
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   typedef enum logic {S_DATA, S_PAR} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              xor_q, xor_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_perr_q, out_perr_d;
   logic              accept;

   // Only the parity bit can stall, and only while an unconsumed word is
   // held; abort always consumes the offered bit.
   assign in_ready = abort
                   | ~((state_q == S_PAR) & out_valid_q & ~out_ready);
   assign accept   = in_valid & in_ready & ~abort;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_perr  = out_perr_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      xor_d       = xor_q;
      word_d      = word_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_perr_d  = out_perr_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (abort) begin
         state_d   = S_DATA;
         bit_cnt_d = '0;
         xor_d     = 1'b0;
      end else if (accept) begin
         unique case (state_q)
            S_DATA: begin
               // Overwrite the slot so stale bits of the last frame vanish.
               word_d = (word_q & ~(ONE << bit_cnt_q))
                      | (DATA_W'(in_bit) << bit_cnt_q);
               xor_d     = xor_q ^ in_bit;
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_cnt_q == CW'(DATA_W - 1)) begin
                  state_d = S_PAR;
               end
            end
            S_PAR: begin
               // A load wins over a same-cycle consume.
               out_data_d  = word_q;
               out_perr_d  = xor_q ^ in_bit ^ ODD_PARITY;
               out_valid_d = 1'b1;
               state_d     = S_DATA;
               bit_cnt_d   = '0;
               xor_d       = 1'b0;
            end
            default: begin
               state_d = S_DATA;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_DATA;
         bit_cnt_q   <= '0;
         xor_q       <= 1'b0;
         word_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_perr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         xor_q       <= xor_d;
         word_q      <= word_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_perr_q  <= out_perr_d;
      end
   end

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Bench for serial_parity_receiver: even and odd parity instances share
// stimulus; table vectors, corner sequences and a randomized model run.
module tb_serial_parity_receiver;

   logic       clk;
   logic       rst_n;
   logic       abort;
   logic       in_valid;
   logic       in_bit;
   logic       out_ready;
   logic       rdy_e, rdy_o;
   logic       ov_e, ov_o;
   logic [7:0] od_e, od_o;
   logic       pe_e, pe_o;

   int n_tests = 0;
   int n_fail  = 0;

   serial_parity_receiver #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (rdy_e),
      .out_valid (ov_e),
      .out_data  (od_e),
      .out_perr  (pe_e),
      .out_ready (out_ready)
   );

   serial_parity_receiver #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (rdy_o),
      .out_valid (ov_o),
      .out_data  (od_o),
      .out_perr  (pe_o),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p,
                             input bit gaps);
      for (int i = 0; i < 9; i++) begin
         int g;
         g = gaps ? $urandom_range(0, 2) : 0;
         repeat (g) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom);
            step();
         end
         in_valid = 1'b1;
         in_bit   = (i < 8) ? d[i] : p;
         step();
      end
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       perr_e;
      logic       perr_o;
   } vec_t;

   vec_t       vecs[8];
   logic [7:0] w;
   bit         q[$];
   logic       mv, mpe, mpo, er, px;
   logic [7:0] md, nw;

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{8'h7F, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0;
      in_bit = 1'b0; out_ready = 1'b1;
      step();
      step();
      chk("rst_ready", 32'(rdy_e), 1);
      chk("rst_valid", 32'(ov_e), 0);
      chk("rst_data", 32'(od_e), 0);
      chk("rst_perr", 32'(pe_e), 0);
      rst_n = 1'b1;

      // Table vectors, consumer always ready.
      for (int v = 0; v < 8; v++) begin
         send_frame(vecs[v].data, vecs[v].par, 1'b0);
         chk("tab_valid", 32'(ov_e), 1);
         chk("tab_data", 32'(od_e), 32'(vecs[v].data));
         chk("tab_perr_even", 32'(pe_e), 32'(vecs[v].perr_e));
         chk("tab_perr_odd", 32'(pe_o), 32'(vecs[v].perr_o));
         step();
         chk("tab_one_cycle", 32'(ov_e), 0);
         chk("tab_retain", 32'(od_e), 32'(vecs[v].data));
      end

      // Backpressure on the parity bit.
      out_ready = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0);
      chk("bp_held_valid", 32'(ov_e), 1);
      chk("bp_held_data", 32'(od_e), 32'hA5);
      w = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_bit   = w[i];
         #1;
         chk("bp_data_ready", 32'(rdy_e), 1);
         step();
      end
      in_valid = 1'b1;
      in_bit   = 1'b0;
      #1;
      chk("bp_par_stall", 32'(rdy_e), 0);
      step();
      chk("bp_stable_valid", 32'(ov_e), 1);
      chk("bp_stable_data", 32'(od_e), 32'hA5);
      chk("bp_stable_perr", 32'(pe_e), 0);
      chk("bp_still_stall", 32'(rdy_e), 0);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1;
      chk("bp_ready_rise", 32'(rdy_e), 1);
      step();
      chk("bp_consumed", 32'(ov_e), 0);
      in_valid = 1'b1;
      in_bit   = 1'b0;
      step();
      in_valid = 1'b0;
      chk("bp_new_valid", 32'(ov_e), 1);
      chk("bp_new_data", 32'(od_e), 32'h3C);
      chk("bp_new_perr", 32'(pe_e), 0);
      step();
      chk("bp_new_once", 32'(ov_e), 0);

      // Gaps in in_valid.
      send_frame(8'hA5, 1'b0, 1'b1);
      chk("gap_valid", 32'(ov_e), 1);
      chk("gap_data", 32'(od_e), 32'hA5);
      chk("gap_perr", 32'(pe_e), 0);
      step();
      chk("gap_once", 32'(ov_e), 0);

      // Abort mid-frame while a word is held.
      out_ready = 1'b0;
      send_frame(8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_bit   = 1'b1;
         step();
      end
      abort = 1'b1;
      #1;
      chk("abt_ready", 32'(rdy_e), 1);
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abt_hold_valid", 32'(ov_e), 1);
      chk("abt_hold_data", 32'(od_e), 32'h01);
      chk("abt_hold_perr", 32'(pe_e), 1);
      out_ready = 1'b1;
      step();
      chk("abt_consumed", 32'(ov_e), 0);
      send_frame(8'h5A, 1'b0, 1'b0);
      chk("abt_valid", 32'(ov_e), 1);
      chk("abt_data", 32'(od_e), 32'h5A);
      chk("abt_perr", 32'(pe_e), 0);
      step();
      chk("abt_once", 32'(ov_e), 0);

      // Reset between clock edges mid-frame.
      out_ready = 1'b0;
      send_frame(8'hC3, 1'b0, 1'b0);
      chk("rmf_held", 32'(ov_e), 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_bit   = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rmf_valid", 32'(ov_e), 0);
      chk("rmf_data", 32'(od_e), 0);
      chk("rmf_ready", 32'(rdy_e), 1);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send_frame(8'h96, 1'b0, 1'b0);
      chk("rmf_new_valid", 32'(ov_e), 1);
      chk("rmf_new_data", 32'(od_e), 32'h96);
      chk("rmf_new_perr_e", 32'(pe_e), 0);
      chk("rmf_new_perr_o", 32'(pe_o), 1);

      // Randomized run against a frame-level model.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      q.delete();
      mv = 1'b0; md = 8'h00; mpe = 1'b0; mpo = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         abort     = ($urandom_range(0, 19) == 0);
         in_valid  = 1'($urandom);
         in_bit    = 1'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         er = abort || !(q.size() == 8 && mv && !out_ready);
         chk("rnd_ready_e", 32'(rdy_e), 32'(er));
         chk("rnd_ready_o", 32'(rdy_o), 32'(er));
         if (abort) begin
            q.delete();
            if (mv && out_ready) mv = 1'b0;
         end else if (in_valid && er) begin
            q.push_back(in_bit);
            if (q.size() == 9) begin
               nw = 8'h00;
               px = 1'b0;
               for (int i = 0; i < 9; i++) begin
                  px = px ^ q[i];
                  if (i < 8) nw = nw + (8'(q[i]) << i);
               end
               md = nw; mpe = px; mpo = ~px; mv = 1'b1;
               q.delete();
            end else if (mv && out_ready) begin
               mv = 1'b0;
            end
         end else if (mv && out_ready) begin
            mv = 1'b0;
         end
         step();
         chk("rnd_valid", 32'(ov_e), 32'(mv));
         chk("rnd_data", 32'(od_e), 32'(md));
         chk("rnd_perr_e", 32'(pe_e), 32'(mpe));
         chk("rnd_perr_o", 32'(pe_o), 32'(mpo));
         chk("rnd_valid_o", 32'(ov_o), 32'(mv));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_parity_receiver.md
SERIAL_PARITY_RECEIVER -- requirements
Module: serial_parity_receiver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data bits per frame (legal range 2..32).
REQ-002 The block SHALL have parameter ODD_PARITY, default 0: 0 = even parity, 1 = odd parity.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous discard of the partial frame.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_bit is valid this cycle.
REQ-008 The block SHALL have port in_bit, input, 1 bit: serial data bit.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts in_bit this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a received word is held.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: received word.
REQ-012 The block SHALL have port out_perr, output, 1 bit: parity error flag for out_data.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word.

Function
REQ-014 A bit SHALL transfer only on a rising edge where in_valid and in_ready are both 1; other cycles leave the receive state unchanged.
REQ-015 The frame SHALL be DATA_W data bits, LSB first, followed by one parity bit.
REQ-016 The block SHALL use two states: DATA (bit_cnt 0..DATA_W-1) and PAR (bit_cnt == DATA_W).
REQ-017 Each accepted bit in DATA SHALL shift into the word at position bit_cnt, fold into a running XOR, and increment bit_cnt.
REQ-018 The DATA-to-PAR transition SHALL occur on acceptance of data bit DATA_W-1.
REQ-019 On acceptance of the parity bit in PAR, the block SHALL load out_data, set out_valid, and return to DATA with bit_cnt = 0 and the running XOR cleared.
REQ-020 out_perr SHALL equal (XOR of all data bits ^ parity bit ^ ODD_PARITY) for the loaded word.
REQ-021 out_valid SHALL rise on the first cycle after the parity-bit transfer (latency 1).
REQ-022 out_valid, out_data and out_perr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 out_valid SHALL clear on a cycle with out_valid=1 and out_ready=1, unless a new word loads in the same cycle; a simultaneous load SHALL win and replace the word.
REQ-024 in_ready SHALL be 0 only when the state is PAR, out_valid=1 and out_ready=0; otherwise it SHALL be 1. Data bits are never back-pressured.
REQ-025 abort=1 SHALL return the state to DATA, clear bit_cnt and the running XOR, and drop any bit offered in the same cycle; abort SHALL NOT affect the out_* registers.
REQ-026 in_ready SHALL be 1 whenever abort=1 so that the dropped bit is consumed.
REQ-027 out_data SHALL retain its last value when out_valid=0.

Reset
REQ-028 While rst_n=0, regardless of clk, the block SHALL force state=DATA, bit_cnt=0, running XOR=0, out_valid=0, out_data=0 and out_perr=0.
REQ-029 While rst_n=0, in_ready SHALL read 1.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame, and the first accepted bit after release SHALL be data bit 0.

Verification
REQ-031 The bench SHALL cover the good frame: DATA_W=8, even parity, bits 1,0,1,0,0,1,0,1 then 0, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_perr=0, one cycle only.
REQ-032 The bench SHALL cover the parity error: word 0x01 followed by parity 0 -> out_data=0x01, out_perr=1; with ODD_PARITY=1 and the same stimulus -> out_perr=0.
REQ-033 The bench SHALL cover backpressure: out_ready=0 with 0xA5 held, second frame 0x3C sent -> in_ready=0 at the parity bit, 0xA5 stays stable; raise out_ready -> 0xA5 consumed, then the parity bit is accepted and 0x3C appears next cycle.
REQ-034 The bench SHALL cover gaps: in_valid toggled randomly during the 0xA5 frame -> same result as the gapless case, no extra or missing bits.
REQ-035 The bench SHALL cover abort: abort after 3 bits of 0xFF, then full frame 0x5A + parity 0 -> exactly one output 0x5A, out_perr=0; held out_* unchanged by abort.
REQ-036 The bench SHALL cover reset mid-frame: rst_n pulsed low between clock edges after 5 bits -> out_valid=0 immediately; next 9 bits form a fresh frame, decoded correctly.
